// File: rtl/mrd_tag_pool_arb_if.sv
// mrd_tag_pool_arb_if: tag request/grant and tag-return bundle between DMA channels and the tag pool
interface mrd_tag_pool_arb_if #(
  parameter int NUM_CHAN = 4,
  parameter int CNT_W    = 9
);
  logic                sys_ena;
  logic [NUM_CHAN-1:0] alloc_tag_req;
  logic [NUM_CHAN-1:0] allocated_tag_rdy;
  logic [7:0]          allocated_tag;
  logic                free_tag_valid;
  logic [7:0]          free_tag;
  logic                err_clr;
  logic [CNT_W-1:0]    tags_in_use;
  logic                pool_empty;
  logic                free_err;
  modport master (
    output sys_ena, alloc_tag_req, free_tag_valid, free_tag, err_clr,
    input  allocated_tag_rdy, allocated_tag, tags_in_use, pool_empty, free_err
  );
  modport slave (
    input  sys_ena, alloc_tag_req, free_tag_valid, free_tag, err_clr,
    output allocated_tag_rdy, allocated_tag, tags_in_use, pool_empty, free_err
  );
endinterface

// File: rtl/mrd_tag_pool_arb.sv
// mrd_tag_pool_arb: round-robin MRd tag allocator with per-channel quota and tag-return checking
module mrd_tag_pool_arb #(
  parameter int NUM_CHAN          = 4,
  parameter int NUM_TAGS          = 32,
  parameter int TAG_BASE          = 0,
  parameter int MAX_TAGS_PER_CHAN = 8,
  parameter int CNT_W             = 9
) (
  input logic               s_axi_clk,
  input logic               s_axi_rstn,
  mrd_tag_pool_arb_if.slave tp
);
  localparam int OW = NUM_CHAN > 1 ? $clog2(NUM_CHAN) : 1;
  localparam int TW = NUM_TAGS > 1 ? $clog2(NUM_TAGS) : 1;
  localparam int QW = $clog2(MAX_TAGS_PER_CHAN + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t              r_state;
  logic [NUM_TAGS-1:0] r_free;
  logic [OW-1:0]       r_owner [NUM_TAGS];
  logic [QW-1:0]       r_cnt [NUM_CHAN];
  logic [OW-1:0]       r_rr;
  logic [NUM_CHAN-1:0] r_rdy;
  logic [7:0]          r_tag;
  logic [CNT_W-1:0]    r_in_use;
  logic                r_empty;
  logic                r_err;
  logic [NUM_CHAN-1:0] w_elig;
  logic                w_grant;
  logic [OW-1:0]       w_win;
  logic [TW-1:0]       w_tidx;
  logic                w_in_rng;
  logic [TW-1:0]       w_fidx;
  logic                w_free_ok;
  logic                w_free_bad;
  logic [OW-1:0]       w_fown;
  logic [CNT_W-1:0]    w_in_use_nx;
  assign tp.allocated_tag_rdy = r_rdy;
  assign tp.allocated_tag     = r_tag;
  assign tp.tags_in_use       = r_in_use;
  assign tp.pool_empty        = r_empty;
  assign tp.free_err          = r_err;
  // Descending scans let the lowest tag index and the nearest channel after the pointer win.
  always_comb begin
    w_tidx = '0;
    for (int t = NUM_TAGS - 1; t >= 0; t--)
      if (r_free[t]) w_tidx = TW'(t);
    for (int c = 0; c < NUM_CHAN; c++)
      w_elig[c] = r_state == IDLE && tp.sys_ena && |r_free && tp.alloc_tag_req[c] &&
                  int'(r_cnt[c]) < MAX_TAGS_PER_CHAN;
    w_grant = |w_elig;
    w_win = '0;
    for (int k = NUM_CHAN - 1; k >= 0; k--)
      if (w_elig[(int'(r_rr) + k) % NUM_CHAN]) w_win = OW'((int'(r_rr) + k) % NUM_CHAN);
    w_in_rng    = int'(tp.free_tag) >= TAG_BASE && int'(tp.free_tag) < TAG_BASE + NUM_TAGS;
    w_fidx      = TW'(int'(tp.free_tag) - TAG_BASE);
    w_free_ok   = tp.free_tag_valid && w_in_rng && !r_free[w_fidx];
    w_free_bad  = tp.free_tag_valid && !w_free_ok;
    w_fown      = r_owner[w_fidx];
    w_in_use_nx = r_in_use + CNT_W'(w_grant) - CNT_W'(w_free_ok);
  end
  always_ff @(posedge s_axi_clk) begin
    if (!s_axi_rstn) begin
      r_state  <= IDLE;
      r_free   <= '1;
      r_rr     <= '0;
      r_rdy    <= '0;
      r_tag    <= '0;
      r_in_use <= '0;
      r_empty  <= 1'b0;
      r_err    <= 1'b0;
      for (int c = 0; c < NUM_CHAN; c++) r_cnt[c] <= '0;
    end else begin
      r_state <= w_grant ? GRANT : IDLE;
      r_rdy   <= w_grant ? NUM_CHAN'(1) << w_win : '0;
      r_tag   <= w_grant ? 8'(int'(w_tidx) + TAG_BASE) : '0;
      if (w_grant) begin
        r_free[w_tidx]  <= 1'b0;
        r_owner[w_tidx] <= w_win;
        r_rr            <= w_win == OW'(NUM_CHAN - 1) ? '0 : w_win + OW'(1);
      end
      // The granted tag was free and the returned tag was busy, so these never collide.
      if (w_free_ok) r_free[w_fidx] <= 1'b1;
      for (int c = 0; c < NUM_CHAN; c++)
        r_cnt[c] <= r_cnt[c] + QW'(w_grant && w_win == OW'(c)) - QW'(w_free_ok && w_fown == OW'(c));
      r_in_use <= w_in_use_nx;
      r_empty  <= w_in_use_nx == CNT_W'(NUM_TAGS);
      r_err    <= w_free_bad | (r_err & ~tp.err_clr);
    end
  end
endmodule
